// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: per-channel L298 PWM drive with soft ramping and dead time on direction reversal
module motor_pwm_ctrl #(
  parameter int CHANNELS = 2,
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 256,
  parameter int DEADTIME = 1024
) (
  input  logic                  W5,
  input  logic                  rst_n,
  input  logic [8*CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0]   pwm,
  output logic [CHANNELS-1:0]   in1,
  output logic [CHANNELS-1:0]   in2,
  output logic [CHANNELS-1:0]   busy
);
  localparam logic [PWM_BITS:0] P_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS:0] P_HALF = P_FULL >> 1;
  localparam logic [PWM_BITS:0] P_QTR  = P_FULL >> 2;
  localparam logic [PWM_BITS:0] P_3Q   = P_HALF + P_QTR;
  localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int TW = DEADTIME > 1 ? $clog2(DEADTIME) : 1;
  localparam logic [2:0] IDLE = 3'd0, RAMP = 3'd1, RUN = 3'd2, DOWN = 3'd3, DEAD = 3'd4;

  logic [8*CHANNELS-1:0] meta_q, sync_q;
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic                  tick;
  logic [CHANNELS-1:0]   pwm_q, pwm_d;

  always_comb begin
    tick  = pre_q == PW'(RAMP_DIV - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge W5 or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      cnt_q  <= '0;
      pre_q  <= '0;
      pwm_q  <= '0;
    end else begin
      meta_q <= sw;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]        s;
    logic [PWM_BITS:0] tgt, duty_q, duty_d;
    logic              tdir, leave, dir_q, dir_d;
    logic [2:0]        st_q, st_d;
    logic [TW-1:0]     dt_q, dt_d;
    always_comb begin
      s     = sync_q[8*c +: 8];
      tgt   = s[0] ? P_FULL : s[1] ? P_3Q : s[2] ? P_HALF : s[3] ? P_QTR :
              s[4] ? P_FULL : s[5] ? P_3Q : s[6] ? P_HALF : s[7] ? P_QTR : '0;
      tdir  = (s[3:0] == 4'd0) && (s[7:4] != 4'd0);
      leave = (tgt == '0) || (tdir != dir_q);
      st_d   = st_q;
      duty_d = duty_q;
      dir_d  = dir_q;
      dt_d   = dt_q;
      case (st_q)
        IDLE: begin
          duty_d = '0;
          if (tgt != '0) begin
            dir_d = tdir;
            st_d  = RAMP;
          end
        end
        RAMP:
          if (leave) st_d = DOWN;
          else if (duty_q == tgt) st_d = RUN;
          else if (tick) duty_d = duty_q < tgt ? duty_q + 1'b1 : duty_q - 1'b1;
        RUN:
          if (leave) st_d = DOWN;
          else if (duty_q != tgt) st_d = RAMP;
        DOWN: begin
          dt_d = '0;
          if (duty_q == '0) st_d = tgt == '0 ? IDLE : tdir != dir_q ? DEAD : RAMP;
          else if (tick) duty_d = duty_q - 1'b1;
        end
        DEAD: begin
          duty_d = '0;
          if (dt_q == TW'(DEADTIME - 1)) begin
            st_d  = tgt == '0 ? IDLE : RAMP;
            dir_d = tgt == '0 ? dir_q : tdir;
          end else begin
            dt_d = dt_q + 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
    always_ff @(posedge W5 or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= IDLE;
        duty_q <= '0;
        dir_q  <= 1'b0;
        dt_q   <= '0;
      end else begin
        st_q   <= st_d;
        duty_q <= duty_d;
        dir_q  <= dir_d;
        dt_q   <= dt_d;
      end
    end
    // legs follow the latched direction; only IDLE and DEAD release both
    assign pwm_d[c] = {1'b0, cnt_q} < duty_q;
    assign in1[c]   = (st_q == RAMP || st_q == RUN || st_q == DOWN) && !dir_q;
    assign in2[c]   = (st_q == RAMP || st_q == RUN || st_q == DOWN) && dir_q;
    assign busy[c]  = st_q == RAMP || st_q == DOWN || st_q == DEAD;
  end
endmodule
